// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares one flash read-command/byte-return channel among
// N_REQ loaders. Commands are latched per requester, granted round-robin one at
// a time, and the returned byte stream is routed only to the current owner.
module flash_read_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                sys_clk,
    input  logic                glbl_rst,
    input  logic [N_REQ-1:0]    req_rden,
    input  logic [N_REQ*25-1:0] req_addr,
    input  logic [N_REQ*24-1:0] req_length,
    output logic [N_REQ-1:0]    req_pending,
    output logic [N_REQ-1:0]    req_grant,
    output logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_last,
    output logic [7:0]          req_data,
    output logic [N_REQ-1:0]    req_done,
    output logic [N_REQ-1:0]    req_error,
    output logic                flash_rden,
    output logic [24:0]         flash_addr,
    output logic [23:0]         flash_length,
    input  logic                flash_valid,
    input  logic                flash_last,
    input  logic [7:0]          flash_data
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;
    state_t state, state_nxt;

    logic [PW-1:0]          ptr, gidx, win_idx;
    logic                   any_pend;
    logic [N_REQ-1:0]       win_oh, rej, acc;
    logic [N_REQ-1:0][24:0] lat_addr;
    logic [N_REQ-1:0][23:0] lat_len;
    logic [23:0]            byte_cnt;
    logic [TW-1:0]          to_cnt;
    logic                   start, xfer_ok, xfer_err;

    // Classify incoming command pulses: a busy index or zero length is rejected.
    always_comb begin
        rej = '0;
        acc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rej[i] = req_rden[i] & (req_pending[i] | req_grant[i] |
                                    (req_length[24*i +: 24] == 24'd0));
            acc[i] = req_rden[i] & ~rej[i];
        end
    end

    // Round-robin pick: first pending index at or after the pointer, wrapping.
    always_comb begin
        int s;
        s        = 0;
        win_idx  = '0;
        any_pend = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= N_REQ) s = s - N_REQ;
            if (req_pending[PW'(s)]) begin
                win_idx  = PW'(s);
                any_pend = 1'b1;
            end
        end
        win_oh = N_REQ'(1) << win_idx;
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state, transfer exit decisions and zero-latency byte routing.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        xfer_ok   = 1'b0;
        xfer_err  = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        case (state)
            S_IDLE: begin
                if (any_pend) begin
                    start     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flash_valid) begin
                    req_valid = req_grant;
                    req_last  = flash_last ? req_grant : '0;
                    req_data  = flash_data;
                    if (flash_last) begin
                        if (byte_cnt + 24'd1 == flash_length) xfer_ok  = 1'b1;
                        else                                  xfer_err = 1'b1;
                    end else if (byte_cnt + 24'd1 == flash_length) begin
                        // Full length delivered but no last marker: overrun.
                        xfer_err = 1'b1;
                    end
                end else if (to_cnt == TO_LAST) begin
                    xfer_err = 1'b1;
                end
                if (xfer_ok | xfer_err) state_nxt = S_RELEASE;
            end
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Per-requester command latches and pending flags.
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            req_pending <= '0;
            lat_addr    <= '0;
            lat_len     <= '0;
        end else begin
            req_pending <= (req_pending & ~(start ? win_oh : '0)) | acc;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc[i]) begin
                    lat_addr[i] <= req_addr[25*i +: 25];
                    lat_len[i]  <= req_length[24*i +: 24];
                end
            end
        end
    end

    // Channel ownership, flash command issue and transfer counters.
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            req_grant    <= '0;
            gidx         <= '0;
            ptr          <= '0;
            flash_rden   <= 1'b0;
            flash_addr   <= '0;
            flash_length <= '0;
            byte_cnt     <= '0;
            to_cnt       <= '0;
        end else begin
            flash_rden <= start;
            if (start) begin
                req_grant    <= win_oh;
                gidx         <= win_idx;
                flash_addr   <= lat_addr[win_idx];
                flash_length <= lat_len[win_idx];
                byte_cnt     <= '0;
                to_cnt       <= '0;
            end else if (state == S_WAIT) begin
                if (flash_valid) begin
                    byte_cnt <= byte_cnt + 24'd1;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
                // Grant drops on exit so the owner may re-request during release.
                if (xfer_ok | xfer_err) begin
                    req_grant <= '0;
                    ptr       <= (gidx == LAST_IDX) ? '0 : gidx + PW'(1);
                end
            end
        end
    end

    // Status pulses; a rejection on the owning index suppresses its done.
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            req_done  <= '0;
            req_error <= '0;
        end else begin
            req_done  <= xfer_ok ? (req_grant & ~rej) : '0;
            req_error <= rej | (xfer_err ? req_grant : '0);
        end
    end
endmodule
